carrier_loop_ctrl: RTL and testbench



---
 rtl/carrier_loop_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_carrier_loop_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carrier_loop_ctrl.sv
// -----------------------------------------------------------------------------
// carrier_loop_ctrl
//
// Supervisor for the MSK carrier-recovery loop. It takes the decision-directed
// phase-error stream from the phase detector and measures the mean |error| over
// fixed windows of 2^WIN_LOG2 symbols. From these measurements it runs an
// IDLE / ACQ / TRACK / RESTART state machine. That state machine selects the
// loop-filter gain shifts, clears the loop filter and NCO, and raises lock.
//
// Ports
//   clk          in   sample clock
//   rst          in   synchronous active-high reset
//   en           in   loop enable; low forces IDLE
//   err_valid    in   one-cycle strobe per symbol error
//   phase_err    in   signed Q2.(EW-2) phase error, valid with err_valid
//   kp_shift     out  proportional gain right-shift for the loop filter
//   ki_shift     out  integral gain right-shift for the loop filter
//   loop_clr     out  clears loop-filter integrator and NCO accumulator
//   lock         out  high while tracking
//   state_o      out  0=IDLE 1=ACQ 2=TRACK 3=RESTART
//   metric       out  mean |err| of the last completed window
//   metric_valid out  one-cycle strobe when metric updates
// -----------------------------------------------------------------------------
module carrier_loop_ctrl #(
    parameter int            EW          = 24,
    parameter int            WIN_LOG2    = 6,
    parameter logic [EW-1:0] LOCK_THR    = 24'h080000,
    parameter logic [EW-1:0] UNLOCK_THR  = 24'h200000,
    parameter int            LOCK_CNT    = 4,
    parameter int            UNLOCK_CNT  = 2,
    parameter int            ACQ_TIMEOUT = 32,
    parameter int            KP_ACQ      = 4,
    parameter int            KI_ACQ      = 10,
    parameter int            KP_TRK      = 7,
    parameter int            KI_TRK      = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 err_valid,
    input  logic signed [EW-1:0] phase_err,
    output logic [3:0]           kp_shift,
    output logic [3:0]           ki_shift,
    output logic                 loop_clr,
    output logic                 lock,
    output logic [1:0]           state_o,
    output logic [EW-1:0]        metric,
    output logic                 metric_valid
);

    // Accumulator is wide enough for a full window of maximum magnitudes.
    localparam int         ACC_W        = EW - 1 + WIN_LOG2;
    localparam logic [3:0] LOCK_CNT_L   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_CNT_L = 4'(UNLOCK_CNT);
    localparam logic [7:0] ACQ_TO_L     = 8'(ACQ_TIMEOUT);
    localparam logic [3:0] KP_ACQ_L     = 4'(KP_ACQ);
    localparam logic [3:0] KI_ACQ_L     = 4'(KI_ACQ);
    localparam logic [3:0] KP_TRK_L     = 4'(KP_TRK);
    localparam logic [3:0] KI_TRK_L     = 4'(KI_TRK);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQ     = 2'd1,
        ST_TRACK   = 2'd2,
        ST_RESTART = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d, sum;
    logic [WIN_LOG2-1:0] sym_q, sym_d;
    logic [3:0]          good_q, good_d;
    logic [3:0]          bad_q, bad_d;
    logic [7:0]          win_q, win_d;
    logic                take, win_end;
    logic [EW-2:0]       mag, mean;
    logic [EW-1:0]       mean_ext;

    // Magnitude of a two's-complement error. The most negative code has no
    // positive counterpart, so it saturates to the largest positive value.
    function automatic logic [EW-2:0] mag_sat(input logic signed [EW-1:0] e);
        logic [EW-2:0] lo;
        lo = e[EW-2:0];
        if (!e[EW-1])
            return lo;
        else if (lo == '0)
            return '1;
        else
            return ~lo + (EW-1)'(1);
    endfunction

    // Errors count only while actively acquiring or tracking; RESTART drops them.
    assign take     = en && err_valid && (state_q == ST_ACQ || state_q == ST_TRACK);
    assign win_end  = take && (sym_q == {WIN_LOG2{1'b1}});
    assign mag      = mag_sat(phase_err);
    assign sum      = acc_q + {{WIN_LOG2{1'b0}}, mag};
    assign mean     = sum[ACC_W-1:WIN_LOG2];
    assign mean_ext = {1'b0, mean};
    assign state_o  = state_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sym_d   = sym_q;
        good_d  = good_q;
        bad_d   = bad_q;
        win_d   = win_q;

        if (take) begin
            if (win_end) begin
                acc_d = '0;
                sym_d = '0;
            end else begin
                acc_d = sum;
                sym_d = sym_q + WIN_LOG2'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                acc_d   = '0;
                sym_d   = '0;
                good_d  = '0;
                bad_d   = '0;
                win_d   = '0;
                state_d = ST_ACQ;
            end
            ST_ACQ: begin
                if (win_end) begin
                    good_d = (mean_ext < LOCK_THR) ? good_q + 4'd1 : 4'd0;
                    win_d  = win_q + 8'd1;
                    // Lock wins over timeout when both land on the same window.
                    if (good_d == LOCK_CNT_L) begin
                        state_d = ST_TRACK;
                        good_d  = '0;
                        bad_d   = '0;
                        win_d   = '0;
                    end else if (win_d == ACQ_TO_L) begin
                        state_d = ST_RESTART;
                    end
                end
            end
            ST_TRACK: begin
                if (win_end) begin
                    // Means between the thresholds also clear bad_d (hysteresis).
                    bad_d = (mean_ext > UNLOCK_THR) ? bad_q + 4'd1 : 4'd0;
                    if (bad_d == UNLOCK_CNT_L) begin
                        state_d = ST_ACQ;
                        good_d  = '0;
                        bad_d   = '0;
                        win_d   = '0;
                    end
                end
            end
            ST_RESTART: begin
                acc_d   = '0;
                sym_d   = '0;
                good_d  = '0;
                bad_d   = '0;
                win_d   = '0;
                state_d = ST_ACQ;
            end
            default: state_d = ST_IDLE;
        endcase

        // Disable discards any partial window.
        if (!en) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            sym_d   = '0;
            good_d  = '0;
            bad_d   = '0;
            win_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            sym_q        <= '0;
            good_q       <= '0;
            bad_q        <= '0;
            win_q        <= '0;
            metric       <= '0;
            metric_valid <= 1'b0;
            loop_clr     <= 1'b1;
            lock         <= 1'b0;
            kp_shift     <= KP_ACQ_L;
            ki_shift     <= KI_ACQ_L;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            sym_q        <= sym_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
            win_q        <= win_d;
            metric_valid <= win_end;
            if (win_end)
                metric <= mean_ext;
            // loop_clr follows the state being entered, so it rises and falls
            // together with state_o.
            loop_clr <= (state_d == ST_IDLE) || (state_d == ST_RESTART);
            // Gains and lock follow the registered state one cycle later;
            // disable drops them at once.
            if (!en) begin
                lock     <= 1'b0;
                kp_shift <= KP_ACQ_L;
                ki_shift <= KI_ACQ_L;
            end else begin
                lock     <= (state_q == ST_TRACK);
                kp_shift <= (state_q == ST_TRACK) ? KP_TRK_L : KP_ACQ_L;
                ki_shift <= (state_q == ST_TRACK) ? KI_TRK_L : KI_ACQ_L;
            end
        end
    end

endmodule

// File: tb/tb_carrier_loop_ctrl.sv
module tb_carrier_loop_ctrl;

    localparam int WIN        = 4;          // 2^WIN_LOG2 with WIN_LOG2=2
    localparam int LOCK_THR   = 'h080000;
    localparam int UNLOCK_THR = 'h200000;
    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_CNT = 2;

    logic clk = 1'b0;
    logic rst, en, err_valid;
    logic signed [23:0] phase_err;

    logic [3:0]  kp_a, ki_a, kp_b, ki_b;
    logic        clr_a, lock_a, mv_a, clr_b, lock_b, mv_b;
    logic [1:0]  st_a, st_b;
    logic [23:0] met_a, met_b;

    always #5 clk = ~clk;

    // Instance a: default acquisition timeout. Instance b: timeout of 3 windows.
    carrier_loop_ctrl #(.EW(24), .WIN_LOG2(2)) dut_a (
        .clk(clk), .rst(rst), .en(en), .err_valid(err_valid), .phase_err(phase_err),
        .kp_shift(kp_a), .ki_shift(ki_a), .loop_clr(clr_a), .lock(lock_a),
        .state_o(st_a), .metric(met_a), .metric_valid(mv_a));

    carrier_loop_ctrl #(.EW(24), .WIN_LOG2(2), .ACQ_TIMEOUT(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .err_valid(err_valid), .phase_err(phase_err),
        .kp_shift(kp_b), .ki_shift(ki_b), .loop_clr(clr_b), .lock(lock_b),
        .state_o(st_b), .metric(met_b), .metric_valid(mv_b));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Mode numbers: 0 idle, 1 acquire, 2 track, 3 restart.
    int     p_tmo[2] = '{32, 3};
    int     m_mode[2], m_good[2], m_bad[2], m_win[2], m_n[2];
    longint m_sum[2], m_metric[2];
    int     m_lock[2], m_kp[2], m_ki[2], m_clr[2], m_mv[2];

    function automatic int mag_of(input int x);
        int a;
        a = (x < 0) ? -x : x;
        if (a > 'h7FFFFF) a = 'h7FFFFF;
        return a;
    endfunction

    task automatic m_clear(input int k);
        m_sum[k] = 0; m_n[k] = 0; m_good[k] = 0; m_bad[k] = 0; m_win[k] = 0;
    endtask

    task automatic model_edge(input int k, input bit r, input bit e, input bit v, input int x);
        int     old;
        longint mean;
        m_mv[k] = 0;
        if (r) begin
            m_mode[k] = 0; m_clear(k); m_metric[k] = 0;
            m_lock[k] = 0; m_kp[k] = 4; m_ki[k] = 10; m_clr[k] = 1;
            return;
        end
        old = m_mode[k];
        if (!e) begin
            m_mode[k] = 0; m_clear(k);
            m_lock[k] = 0; m_kp[k] = 4; m_ki[k] = 10; m_clr[k] = 1;
            return;
        end
        if (old == 0 || old == 3) begin
            m_mode[k] = 1;
            m_clear(k);
        end else if (v) begin
            m_sum[k] += mag_of(x);
            m_n[k]++;
            if (m_n[k] == WIN) begin
                mean = m_sum[k] / WIN;
                m_metric[k] = mean;
                m_mv[k] = 1;
                m_sum[k] = 0;
                m_n[k] = 0;
                if (old == 1) begin
                    m_win[k]++;
                    m_good[k] = (mean < LOCK_THR) ? m_good[k] + 1 : 0;
                    if (m_good[k] == LOCK_CNT) begin
                        m_mode[k] = 2; m_clear(k);
                    end else if (m_win[k] == p_tmo[k]) begin
                        m_mode[k] = 3;
                    end
                end else begin
                    m_bad[k] = (mean > UNLOCK_THR) ? m_bad[k] + 1 : 0;
                    if (m_bad[k] == UNLOCK_CNT) begin
                        m_mode[k] = 1; m_clear(k);
                    end
                end
            end
        end
        m_lock[k] = (old == 2) ? 1 : 0;
        m_kp[k]   = (old == 2) ? 7 : 4;
        m_ki[k]   = (old == 2) ? 14 : 10;
        m_clr[k]  = (m_mode[k] == 0 || m_mode[k] == 3) ? 1 : 0;
    endtask

    task automatic check_model();
        chk("a_state", st_a, m_mode[0]);   chk("b_state", st_b, m_mode[1]);
        chk("a_lock", lock_a, m_lock[0]);  chk("b_lock", lock_b, m_lock[1]);
        chk("a_kp", kp_a, m_kp[0]);        chk("b_kp", kp_b, m_kp[1]);
        chk("a_ki", ki_a, m_ki[0]);        chk("b_ki", ki_b, m_ki[1]);
        chk("a_clr", clr_a, m_clr[0]);     chk("b_clr", clr_b, m_clr[1]);
        chk("a_mv", mv_a, m_mv[0]);        chk("b_mv", mv_b, m_mv[1]);
        chk("a_metric", met_a, m_metric[0]);
        chk("b_metric", met_b, m_metric[1]);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, sample.
    task automatic step(input int r, input int e, input int v, input int x, input int cmp);
        rst       = (r != 0);
        en        = (e != 0);
        err_valid = (v != 0);
        phase_err = 24'(x);
        @(posedge clk);
        model_edge(0, rst, en, err_valid, int'(phase_err));
        model_edge(1, rst, en, err_valid, int'(phase_err));
        #1;
        if (cmp != 0) check_model();
    endtask

    task automatic errs(input int n, input int x);
        for (int i = 0; i < n; i++) step(0, 1, 1, x, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 1);
    endtask

    task automatic restart_acq();
        step(1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
    endtask

    typedef struct {
        int r, e, v, x;
        int st, lk, kp, ki, clr, mv, met;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int amp;
        int amps[4] = '{'h8000, 'hC0000, 'h300000, 'h7FFFFF};
        int x;

        rst = 1'b1; en = 1'b0; err_valid = 1'b0; phase_err = '0;

        // Reset with errors toggling, enable with an ignored error, then lock.
        tbl.push_back('{1, 0, 1, 'h100000, 0, 0, 4, 10, 1, 0, 0});
        tbl.push_back('{1, 1, 0, 0,        0, 0, 4, 10, 1, 0, 0});
        tbl.push_back('{1, 1, 1, 'h100000, 0, 0, 4, 10, 1, 0, 0});
        tbl.push_back('{0, 0, 1, 'h100000, 0, 0, 4, 10, 1, 0, 0});
        tbl.push_back('{0, 1, 1, 'h010000, 1, 0, 4, 10, 0, 0, 0});
        for (int w = 0; w < 4; w++)
            for (int s = 0; s < 4; s++)
                tbl.push_back('{0, 1, 1, 'h010000,
                                (w == 3 && s == 3) ? 2 : 1, 0, 4, 10, 0,
                                (s == 3) ? 1 : 0,
                                (w == 0 && s < 3) ? 0 : 'h010000});
        tbl.push_back('{0, 1, 0, 0,         2, 1, 7, 14, 0, 0, 'h010000});
        tbl.push_back('{0, 1, 1, -'h010000, 2, 1, 7, 14, 0, 0, 'h010000});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].x, 0);
            chk($sformatf("tbl%0d_state", i), st_a, tbl[i].st);
            chk($sformatf("tbl%0d_lock", i), lock_a, tbl[i].lk);
            chk($sformatf("tbl%0d_kp", i), kp_a, tbl[i].kp);
            chk($sformatf("tbl%0d_ki", i), ki_a, tbl[i].ki);
            chk($sformatf("tbl%0d_clr", i), clr_a, tbl[i].clr);
            chk($sformatf("tbl%0d_mv", i), mv_a, tbl[i].mv);
            chk($sformatf("tbl%0d_metric", i), met_a, tbl[i].met);
        end

        // Lock with errors spaced 20 cycles apart.
        restart_acq();
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 1, 'h010000, 1);
            if (i == 15) begin
                chk("sparse_state_1", st_a, 2);
                chk("sparse_lock_1", lock_a, 0);
            end
            step(0, 1, 0, 0, 1);
            if (i == 15) begin
                chk("sparse_lock_2", lock_a, 1);
                chk("sparse_kp_2", kp_a, 7);
                chk("sparse_ki_2", ki_a, 14);
            end
            idle(18);
        end

        // Most negative error saturates; the bad window clears the good count.
        restart_acq();
        errs(4, 'h010000);
        errs(4, -'h800000);
        chk("sat_metric", met_a, 'h7FFFFF);
        chk("sat_mv", mv_a, 1);
        errs(12, 'h010000);
        idle(2);
        chk("sat_still_acq", st_a, 1);
        errs(4, 'h010000);
        idle(1);
        chk("sat_then_track", st_a, 2);

        // Acquisition timeout on instance b; the RESTART-cycle symbol is dropped.
        restart_acq();
        errs(12, 'h300000);
        chk("tmo_state_restart", st_b, 3);
        chk("tmo_clr_high", clr_b, 1);
        step(0, 1, 1, 'h7FFFFF, 1);
        chk("tmo_state_acq", st_b, 1);
        chk("tmo_clr_low", clr_b, 0);
        errs(4, 'h010000);
        chk("tmo_fresh_mv", mv_b, 1);
        chk("tmo_fresh_metric", met_b, 'h010000);

        // Track hysteresis: bad, mid, bad, bad.
        restart_acq();
        errs(16, 'h010000);
        idle(2);
        errs(4, 'h250000);
        errs(4, 'h150000);
        errs(4, 'h250000);
        chk("hyst_hold_state", st_a, 2);
        chk("hyst_hold_lock", lock_a, 1);
        errs(4, 'h250000);
        chk("hyst_drop_state", st_a, 1);
        chk("hyst_drop_clr", clr_a, 0);
        chk("hyst_drop_lock_late", lock_a, 1);
        idle(1);
        chk("hyst_lock_off", lock_a, 0);
        chk("hyst_kp_acq", kp_a, 4);
        chk("hyst_ki_acq", ki_a, 10);
        chk("hyst_clr_off", clr_a, 0);

        // Disable mid-window in TRACK, then re-enable with a fresh window.
        restart_acq();
        errs(16, 'h010000);
        errs(4, 'h020000);
        errs(2, 'h100000);
        step(0, 0, 0, 0, 1);
        chk("dis_state", st_a, 0);
        chk("dis_clr", clr_a, 1);
        chk("dis_lock", lock_a, 0);
        chk("dis_metric_held", met_a, 'h020000);
        step(0, 1, 0, 0, 1);
        chk("reen_state", st_a, 1);
        chk("reen_clr", clr_a, 0);
        errs(4, 'h040000);
        chk("reen_mv", mv_a, 1);
        chk("reen_metric", met_a, 'h040000);

        // Randomized stimulus against the model.
        restart_acq();
        amp = amps[0];
        for (int c = 0; c < 4000; c++) begin
            if (c % 256 == 0) amp = amps[$urandom_range(3, 0)];
            if ($urandom_range(49, 0) == 0)
                x = -'h800000;
            else
                x = int'($urandom_range(2 * amp, 0)) - amp;
            step(($urandom_range(999, 0) == 0) ? 1 : 0,
                 ($urandom_range(99, 0) != 0) ? 1 : 0,
                 int'($urandom_range(1, 0)), x, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
